// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM port status and responder FSM.
// The RAM responder's encodings live here so memory_control and benches agree.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_BUSY,
        R_ACCESS,
        R_ERROR
    } ram_fsm_t;

    // FSM state to externally visible RAM status (one to one)
    function automatic ramstate_t to_ramstate(ram_fsm_t s);
        ramstate_t r;
        unique case (s)
            R_IDLE:   r = FREE;
            R_BUSY:   r = BUSY;
            R_ACCESS: r = ACCESS;
            R_ERROR:  r = ERROR;
            default:  r = FREE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_word_array.sv
// DEPTH x word_t storage with one synchronous write and one synchronous read port.
// Storage is never reset; only the read data register clears on RST.
import cpu_types_pkg::*;

module ram_word_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  word_t         wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];
    word_t rdata_q;

    // Write port: caller gates we_i so no write lands during reset
    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered data, holds between reads
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Behavioural RAM responder with fixed access latency and completion counters.
// Optional RAM_BOUNDS_CHECK_EN turns out-of-range word addresses into ERROR.
import cpu_types_pkg::*;

module ram_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4096,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ramREN,
    input  logic             ramWEN,
    input  logic [31:0]      ramaddr,
    input  word_t            ramstore,
    output word_t            ramload,
    output ramstate_t        ramstate,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int LATM1 = (LAT > 0) ? LAT - 1 : 0;

    ram_fsm_t         state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [29:0]      addr_q, addr_d;
    word_t            store_q, store_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

    logic        req;
    logic        both;
    logic        oob;
    logic        changed;
    logic        acc;
    logic [29:0] waddr;
    logic        addr_unused;

    assign req   = ramREN | ramWEN;
    assign both  = ramREN & ramWEN;
    assign waddr = ramaddr[31:2];
    assign addr_unused = ^ramaddr[1:0];

`ifdef RAM_BOUNDS_CHECK_EN
    assign oob = (waddr >= 30'(DEPTH));
`else
    assign oob = 1'b0;
`endif

    assign changed = (ramWEN != op_q) ||
                     (waddr != addr_q) ||
                     (ramstore != store_q);

    // Next state, latency counter, request latch and access strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        addr_d  = addr_q;
        store_d = store_q;
        acc     = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                if (both || (req && oob)) begin
                    state_d = R_ERROR;
                end else if (req) begin
                    op_d    = ramWEN;
                    addr_d  = waddr;
                    store_d = ramstore;
                    if (LAT == 0) begin
                        acc     = 1'b1;
                        state_d = R_ACCESS;
                    end else begin
                        cnt_d   = CW'(LATM1);
                        state_d = R_BUSY;
                    end
                end
            end
            R_BUSY: begin
                if (!req) begin
                    state_d = R_IDLE;
                end else if (both || oob) begin
                    state_d = R_ERROR;
                end else if (changed) begin
                    op_d    = ramWEN;
                    addr_d  = waddr;
                    store_d = ramstore;
                    cnt_d   = CW'(LATM1);
                end else if (cnt_q == '0) begin
                    acc     = 1'b1;
                    state_d = R_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            R_ACCESS: state_d = R_IDLE;
            R_ERROR:  state_d = R_IDLE;
            default:  state_d = R_IDLE;
        endcase
    end

    // Completion counters advance on the edge that performs the access
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (acc && ramREN) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (acc && ramWEN) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= R_IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    ram_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .CLK     (CLK),
        .RST     (RST),
        .we_i    (acc & ramWEN & ~RST),
        .waddr_i (ramaddr[2 +: AW]),
        .wdata_i (ramstore),
        .re_i    (acc & ramREN & ~RST),
        .raddr_i (ramaddr[2 +: AW]),
        .rdata_o (ramload)
    );

    assign ramstate = to_ramstate(state_q);
    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder (LAT=2, DEPTH=4096, CNT_W=16).
// Expectations follow RAM_BOUNDS_CHECK_EN when it is defined.
import cpu_types_pkg::*;

module tb_ram_responder;

    logic        clk;
    logic        rst;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    ramstate_t   st;
    logic [15:0] rdc;
    logic [15:0] wrc;

    int nvec;
    int nerr;

    ram_responder #(
        .LAT   (2),
        .DEPTH (4096),
        .CNT_W (16)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .ramREN   (ren),
        .ramWEN   (wen),
        .ramaddr  (addr),
        .ramstore (store),
        .ramload  (load),
        .ramstate (st),
        .rd_count (rdc),
        .wr_count (wrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input ramstate_t exp);
        chk(tag, {30'b0, st}, {30'b0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int r, input int w);
        chk({tag, "_rd"}, {16'b0, rdc}, r[31:0]);
        chk({tag, "_wr"}, {16'b0, wrc}, w[31:0]);
    endtask

    // Full request: FREE, 2 BUSY, 1 ACCESS (with read data), requests dropped
    task automatic op(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_load);
        @(negedge clk);
        chk_st({tag, "_free"}, FREE);
        ren = ~w;
        wen = w;
        addr = a;
        store = d;
        repeat (2) begin
            @(negedge clk);
            chk_st({tag, "_busy"}, BUSY);
        end
        @(negedge clk);
        chk_st({tag, "_access"}, ACCESS);
        if (!w) chk({tag, "_load"}, load, exp_load);
        ren = 1'b0;
        wen = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        ren = 1'b0;
        wen = 1'b0;
        addr = '0;
        store = '0;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_st("rst_state", FREE);
        chk("rst_load", load, 32'h0);
        chk_cnt("rst", 0, 0);

        // Write then read 0x40
        op("wr40", 1'b1, 32'h40, 32'hDEADBEEF, 32'h0);
        op("rd40", 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        @(negedge clk);
        chk_cnt("wr_rd", 1, 1);

        // Restart on address change during BUSY
        op("wr84", 1'b1, 32'h84, 32'hA5A50084, 32'h0);
        op("wr80", 1'b1, 32'h80, 32'h00000080, 32'h0);
        @(negedge clk);
        chk_st("rs_free", FREE);
        ren = 1'b1;
        addr = 32'h80;
        @(negedge clk);
        chk_st("rs_busy0", BUSY);
        addr = 32'h84;
        repeat (2) begin
            @(negedge clk);
            chk_st("rs_busy", BUSY);
        end
        @(negedge clk);
        chk_st("rs_access", ACCESS);
        chk("rs_load", load, 32'hA5A50084);
        ren = 1'b0;
        @(negedge clk);
        chk_cnt("rs", 2, 3);

        // Both requests high -> ERROR
        op("wr10", 1'b1, 32'h10, 32'h12345678, 32'h0);
        @(negedge clk);
        ren = 1'b1;
        wen = 1'b1;
        addr = 32'h10;
        store = 32'hFFFFFFFF;
        @(negedge clk);
        chk_st("err_state", ERROR);
        ren = 1'b0;
        wen = 1'b0;
        @(negedge clk);
        chk_st("err_free", FREE);
        chk_cnt("err", 2, 4);
        op("rd10", 1'b0, 32'h10, 32'h0, 32'h12345678);

        // Abort a write by dropping WEN in BUSY
        op("wr20", 1'b1, 32'h20, 32'h22222222, 32'h0);
        @(negedge clk);
        wen = 1'b1;
        addr = 32'h20;
        store = 32'h11111111;
        @(negedge clk);
        chk_st("ab_busy", BUSY);
        wen = 1'b0;
        @(negedge clk);
        chk_st("ab_free", FREE);
        op("rd20", 1'b0, 32'h20, 32'h0, 32'h22222222);
        @(negedge clk);
        chk_cnt("ab", 4, 5);

        // Word 4096: alias of word 0, or ERROR with bounds checking
        op("wr00", 1'b1, 32'h0, 32'hCAFE0000, 32'h0);
`ifdef RAM_BOUNDS_CHECK_EN
        @(negedge clk);
        ren = 1'b1;
        addr = 32'h4000;
        @(negedge clk);
        chk_st("oob_err", ERROR);
        ren = 1'b0;
        @(negedge clk);
        chk_cnt("oob", 4, 6);
`else
        op("alias", 1'b0, 32'h4000, 32'h0, 32'hCAFE0000);
        @(negedge clk);
        chk_cnt("alias", 5, 6);
`endif

        // Reset on the edge that would complete a write drops it
        op("wr44", 1'b1, 32'h44, 32'h44444444, 32'h0);
        @(negedge clk);
        wen = 1'b1;
        addr = 32'h44;
        store = 32'h99999999;
        repeat (2) begin
            @(negedge clk);
            chk_st("rb_busy", BUSY);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wen = 1'b0;
        chk_st("rb_free", FREE);
        chk("rb_load", load, 32'h0);
        chk_cnt("rb", 0, 0);
        op("rd44", 1'b0, 32'h44, 32'h0, 32'h44444444);
        @(negedge clk);
        chk_cnt("end", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
